// File: rtl/axi4stream_pkg.sv
// Shared AXI4-Stream widths and the arbiter state type for the stream blocks.
package axi4stream_pkg;

    localparam int DW = 32;
    localparam int KW = DW / 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PKT  = 1'b1
    } arb_state_t;

    // Index width for an N-entry selector; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/str_rr_pick.sv
// Combinational round-robin picker: first set request searching upward,
// with wrap, from the slot after ptr. Returns a one-hot grant and its index.
module str_rr_pick
    import axi4stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             base;
    int             hit;
    int             win;

    // Rotate the doubled request vector so the slot after ptr lands on bit 0.
    always_comb begin
        base = int'(ptr) + 1;
        if (base >= N) begin
            base = 0;
        end
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> base);
    end

    // Priority-encode the rotated vector; the lowest set bit is the winner.
    always_comb begin
        hit = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                hit = i;
            end
        end
    end

    // Undo the rotation to get the absolute input index and its one-hot form.
    always_comb begin
        gnt = '0;
        idx = '0;
        win = 0;
        if (hit >= 0) begin
            win = base + hit;
            if (win >= N) begin
                win = win - N;
            end
            gnt = N'(1) << win;
            idx = PW'(win);
        end
    end

endmodule

// File: rtl/str_arb.sv
// Packet-locked round-robin arbiter sharing one registered AXI4-Stream output
// between N sources. An owner keeps the output until its tlast beat is taken.
module str_arb
    import axi4stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = axi4stream_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    output logic [N-1:0]  grant
);

    localparam int PW = idx_width(N);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          own_valid;
    logic          own_last;
    logic [DW-1:0] own_data;
    logic          out_free;
    logic          accept;

    str_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (s_tvalid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Route the current owner's valid, last and data lane to the output path.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (PW'(i) == owner) begin
                own_valid = s_tvalid[i];
                own_last  = s_tlast[i];
                own_data  = s_tdata[i*DW +: DW];
            end
        end
    end

    // The output register can take a beat when it is empty or being drained;
    // only the owner sees that, everyone else just sees ready low.
    always_comb begin
        out_free = m_tready | ~m_tvalid;
        accept   = (state == ARB_PKT) & own_valid & out_free;
        s_tready = grant & {N{out_free}};
    end

    // Arbitration FSM, round-robin pointer and the registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            ptr      <= PW'(N - 1);
            owner    <= '0;
            grant    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= own_data;
                m_tlast  <= own_last;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (|s_tvalid) begin
                        state <= ARB_PKT;
                        grant <= pick_gnt;
                        owner <= pick_idx;
                    end
                end
                ARB_PKT: begin
                    if (accept && own_last) begin
                        state <= ARB_IDLE;
                        grant <= '0;
                        ptr   <= owner;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/str_arb.md
# str_arb

Round-robin, packet-locked arbiter that shares one AXI4-Stream output between `N` stream sources. It is synthesizable RTL and sits between the `str_src` bus-functional sources (or real producers) and a single downstream `str_drn`/consumer.
- Once an input wins, it keeps the output until its `tlast` beat is accepted, so packets are never interleaved.
- The output is registered. Within a packet, throughput is one beat per clock.

## Interface
Parameters:
- `N`, 4: number of input streams (1..16).
- `DW`, `axi4stream_pkg::DW` (32): tdata width.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `s_tvalid`  in  N  per-input valid.
- `s_tready`  out  N  per-input ready; at most one bit set.
- `s_tdata`  in  N*DW  input data; input i occupies bits [i*DW +: DW].
- `s_tlast`  in  N  per-input end-of-packet.
- `m_tvalid`  out  1  output valid (registered).
- `m_tready`  in  1  output ready.
- `m_tdata`  out  DW  output data (registered).
- `m_tlast`  out  1  output end-of-packet (registered).
- `grant`  out  N  one-hot current owner; 0 when idle.

## Operation
- FSM has two states, IDLE and PKT.
- IDLE → PKT: on the clock edge where any `s_tvalid` bit is 1, the winner is latched into `grant`.
  - The winner is the first valid input searching upward, with wrap, from `ptr+1`.
  - `ptr` is the previous winner.
- In IDLE, `s_tready` = 0.
- In PKT with owner g:
  - `s_tready[g] = m_tready | ~m_tvalid`; all other `s_tready` bits are 0.
  - A beat is accepted when `s_tvalid[g] & s_tready[g]`. On acceptance: `m_tdata <= s_tdata[g]`, `m_tlast <= s_tlast[g]`, `m_tvalid <= 1`.
- `m_tvalid` falls to 0 when `m_tready` is 1 and no new beat is accepted in that cycle.
- PKT → IDLE: on acceptance of a beat with `s_tlast[g]` = 1.
  - At the same edge: `ptr <= g` and `grant <= 0`.
- If the owner drops `s_tvalid` mid-packet, it keeps `grant`. There is no timeout and no switching to another input.
- Non-owner inputs are never stalled combinationally by the owner; their `s_tready` is simply 0.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `s_tready`=0, `grant`=0, state=IDLE, `ptr`=N-1 (so input 0 has first priority).
- Latency: `s_tvalid` rising in IDLE at edge k gives `grant` at k+1. The first beat is accepted at k+2 and `m_tvalid` is high after edge k+2.
- Between packets there is exactly one IDLE cycle on the input side. Any output backlog (the registered last beat) drains concurrently.
- Output stability: while `m_tvalid & ~m_tready`, `m_tdata` and `m_tlast` hold and `s_tready[g]`=0.
- Single-beat packets: grant is held for exactly the acceptance cycle, then IDLE follows.
- All inputs continuously valid, 1-beat packets: grant order 0,1,…,N-1,0…; one packet every 2 cycles.
- A new request arriving in the same cycle the owner's `tlast` is accepted is not seen until the IDLE cycle that follows.
- `rst` mid-packet: everything returns to reset values on the next edge. The beat in the output register is discarded, and the partial packet is not completed.
- N=1 degenerates to a registered pass-through with the one-cycle inter-packet gap.

## Structure
- `axi4stream_pkg` holds `KW`, `DW`, and the FSM typedef `arb_state_t {ARB_IDLE, ARB_PKT}`.
- Sub-module `str_rr_pick #(N)` is a combinational round-robin picker.
  - Inputs: `req[N]`, `ptr` ($clog2(N) bits).
  - Outputs: one-hot `gnt[N]` and index `idx`.
  - Implementation: double-width request vector, rotate, priority-encode.
- `str_arb` contains the FSM, `ptr` register, output register, and the data mux.

## Test plan
- Reset, then input 2 sends a 3-beat packet A0..A2 with `m_tready`=1. Expected: `grant`=4'b0100 one cycle after valid; `m_tdata` = A0,A1,A2 on consecutive cycles; `m_tlast` on A2; `grant`=0 afterwards.
- Inputs 0..3 all continuously valid, each sending 2-beat packets. Expected: output packet owners come out in order 0,1,2,3,0,1 with no interleaving of beats.
- Input 1 is mid-packet while `m_tready` toggles 1,0,0,1. Expected: `m_tdata` is held stable during the stall; no beats are lost or duplicated; `s_tready[1]` = 0 while stalled.
- Owner 3 drops `s_tvalid` for 4 cycles mid-packet while input 0 is valid. Expected: `grant` stays at 3 and input 0 receives no `s_tready` until input 3's `tlast` is accepted.
- Assert `rst` for one cycle during beat 2 of a 4-beat packet. Expected: all outputs are 0 the next cycle. Input 0 then wins first when inputs 0 and 3 request together.
